udp_frame_buffer: RTL and testbench

Packet buffer directly downstream of the UDP filter. Accepts speculative word writes while the filter inspects a frame, commits the frame when the filter marks it valid, and discards it on the filter's flush request. Committed frames are replayed as an AXI-Stream master with `tlast`, so only accepted UDP frames leave the filter path.

---
 rtl/udp_filter_pkg.sv | 6 +
 rtl/udp_frame_buffer_if.sv | 9 +
 rtl/udp_frame_ram.sv | 19 +
 rtl/udp_frame_buffer.sv | 88 ++++++++
 tb/tb_udp_frame_buffer.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/udp_filter_pkg.sv
// udp_filter_pkg: shared types and constants for the UDP filter path and its frame buffer.
package udp_filter_pkg;
   localparam int DEFAULT_DATA_WIDTH = 64;
   localparam int DROP_CNT_WIDTH = 16;
   typedef enum logic [1:0] {IDLE, FETCH, SEND} udp_frame_buf_state_t;
endpackage

// File: rtl/udp_frame_buffer_if.sv
// udp_frame_buffer_if: AXI-Stream channel carrying replayed frames out of the buffer.
interface udp_frame_buffer_if #(parameter int DATA_WIDTH = udp_filter_pkg::DEFAULT_DATA_WIDTH);
   logic [DATA_WIDTH-1:0] tdata;
   logic tvalid;
   logic tlast;
   logic tready;
   modport master (output tdata, tvalid, tlast, input tready);
   modport slave (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/udp_frame_ram.sv
// udp_frame_ram: simple dual-port RAM with a registered, enable-gated read port.
module udp_frame_ram #(
   parameter int DATA_WIDTH = udp_filter_pkg::DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  clk_i,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  rd_en_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o
);
   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
   always_ff @(posedge clk_i) begin
      if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
      if (rd_en_i) rd_data_o <= mem[rd_addr_i];
   end
endmodule

// File: rtl/udp_frame_buffer.sv
// udp_frame_buffer: stores speculative words from the UDP filter, keeps committed frames,
// and replays them as an AXI-Stream master with tlast on each frame's final word.
module udp_frame_buffer #(
   parameter int DATA_WIDTH = udp_filter_pkg::DEFAULT_DATA_WIDTH,
   parameter int DEPTH = 512,
   parameter int FRAMES = 8
) (
   input  logic                  clk_i,
   input  logic                  a_rst_n_i,
   input  logic                  wr_en_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  commit_i,
   input  logic                  flush_n_i,
   output logic                  empty_o,
   output logic                  full_o,
   output logic [udp_filter_pkg::DROP_CNT_WIDTH-1:0] drop_cnt_o,
   udp_frame_buffer_if.master    m_axis
);
   import udp_filter_pkg::*;
   localparam int ADDR_WIDTH = $clog2(DEPTH);
   localparam int FRM_WIDTH = $clog2(FRAMES);
   localparam int PW = ADDR_WIDTH + 1;
   logic [PW-1:0] wr_ptr, cm_ptr, rd_ptr, rd_inc, wr_end, wr_next, cm_next;
   logic [PW-1:0] bq [FRAMES];
   logic [FRM_WIDTH:0] bq_wr, bq_rd;
   logic ovf, ovf_now, wr_ok, do_drop, do_push, bq_full, fire;
   logic [DATA_WIDTH-1:0] rd_data;
   udp_frame_buf_state_t state, state_d;
   assign full_o = (wr_ptr - rd_ptr) == PW'(DEPTH);
   assign empty_o = wr_ptr == rd_ptr;
   assign rd_inc = rd_ptr + 1'b1;
   assign bq_full = (bq_wr - bq_rd) == (FRM_WIDTH+1)'(FRAMES);
   assign m_axis.tvalid = state == SEND;
   assign m_axis.tlast = m_axis.tvalid && rd_inc == bq[bq_rd[FRM_WIDTH-1:0]];
   assign m_axis.tdata = m_axis.tvalid ? rd_data : '0;
   assign fire = m_axis.tvalid && m_axis.tready;
   // cm_next lets IDLE see a commit in its own cycle, giving tvalid two cycles after commit
   always_comb begin
      wr_ok = wr_en_i && !full_o;
      wr_end = wr_ptr + PW'(wr_ok);
      ovf_now = ovf || (wr_en_i && full_o);
      do_drop = flush_n_i && commit_i && (ovf_now || bq_full);
      do_push = flush_n_i && commit_i && !do_drop && wr_end != cm_ptr;
      cm_next = do_push ? wr_end : cm_ptr;
      wr_next = (!flush_n_i || do_drop) ? cm_ptr : wr_end;
      state_d = state;
      case (state)
         IDLE:    state_d = rd_ptr != cm_next ? FETCH : IDLE;
         FETCH:   state_d = SEND;
         SEND:    state_d = !fire ? SEND : rd_inc != cm_next ? FETCH : IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or negedge a_rst_n_i) begin
      if (!a_rst_n_i) begin
         wr_ptr <= '0;
         cm_ptr <= '0;
         rd_ptr <= '0;
         bq_wr <= '0;
         bq_rd <= '0;
         ovf <= 1'b0;
         drop_cnt_o <= '0;
         state <= IDLE;
         for (int i = 0; i < FRAMES; i++) bq[i] <= '0;
      end else begin
         wr_ptr <= wr_next;
         cm_ptr <= cm_next;
         ovf <= flush_n_i && !commit_i && ovf_now;
         state <= state_d;
         if (fire) rd_ptr <= rd_inc;
         if (fire && m_axis.tlast) bq_rd <= bq_rd + 1'b1;
         if (do_push) begin
            bq[bq_wr[FRM_WIDTH-1:0]] <= wr_end;
            bq_wr <= bq_wr + 1'b1;
         end
         if (do_drop && drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
      end
   end
   udp_frame_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
      .clk_i     (clk_i),
      .wr_en_i   (wr_ok && flush_n_i),
      .wr_addr_i (wr_ptr[ADDR_WIDTH-1:0]),
      .wr_data_i (wr_data_i),
      .rd_en_i   (state == FETCH),
      .rd_addr_i (rd_ptr[ADDR_WIDTH-1:0]),
      .rd_data_o (rd_data)
   );
endmodule

// File: tb/tb_udp_frame_buffer.sv
// tb_udp_frame_buffer: randomized and directed frames checked against a queue-based frame model.
module tb_udp_frame_buffer;
   localparam int DEPTH = 16;
   localparam int FRAMES = 8;
   typedef struct {logic [63:0] d; logic l;} beat_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic wr_en = 1'b0;
   logic [63:0] wr_data = '0;
   logic commit = 1'b0;
   logic flush_n = 1'b1;
   logic empty, full;
   logic [15:0] drop_cnt;
   logic rnd = 1'b0;
   int errs = 0;
   int checks = 0;
   logic [63:0] pend[$];
   beat_t expq[$];
   int nfr = 0;
   logic [15:0] m_drop = '0;
   logic m_ovf = 1'b0;
   logic stall = 1'b0;
   logic [63:0] st_data = '0;
   logic st_last = 1'b0;
   udp_frame_buffer_if #(.DATA_WIDTH(64)) axis ();
   udp_frame_buffer #(.DATA_WIDTH(64), .DEPTH(DEPTH), .FRAMES(FRAMES)) dut (
      .clk_i      (clk),
      .a_rst_n_i  (rst_n),
      .wr_en_i    (wr_en),
      .wr_data_i  (wr_data),
      .commit_i   (commit),
      .flush_n_i  (flush_n),
      .empty_o    (empty),
      .full_o     (full),
      .drop_cnt_o (drop_cnt),
      .m_axis     (axis.master)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   // Model state advances at the negedge using the inputs the DUT will sample next posedge
   always @(negedge clk) begin
      int occ;
      int nfr0;
      logic fl;
      logic on;
      beat_t e;
      if (!rst_n) begin
         pend.delete();
         expq.delete();
         nfr = 0;
         m_drop = '0;
         m_ovf = 1'b0;
         stall = 1'b0;
      end else begin
         occ = pend.size() + expq.size();
         nfr0 = nfr;
         chk("empty", 64'(empty), 64'(occ == 0));
         chk("full", 64'(full), 64'(occ == DEPTH));
         chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
         if (stall) begin
            chk("stall_valid", 64'(axis.tvalid), 64'(1));
            chk("stall_data", axis.tdata, st_data);
            chk("stall_last", 64'(axis.tlast), 64'(st_last));
         end
         if (axis.tvalid && expq.size() == 0) chk("stray_valid", 64'(axis.tvalid), 64'(0));
         else if (axis.tvalid && axis.tready) begin
            e = expq.pop_front();
            chk("tdata", axis.tdata, e.d);
            chk("tlast", 64'(axis.tlast), 64'(e.l));
            if (e.l) nfr--;
         end
         stall = axis.tvalid && !axis.tready;
         st_data = axis.tdata;
         st_last = axis.tlast;
         if (!flush_n) begin
            pend.delete();
            m_ovf = 1'b0;
         end else begin
            fl = occ == DEPTH;
            if (wr_en && !fl) pend.push_back(wr_data);
            on = m_ovf || (wr_en && fl);
            if (commit) begin
               if (on || nfr0 == FRAMES) begin
                  pend.delete();
                  if (m_drop != 16'hFFFF) m_drop++;
               end else if (pend.size() > 0) begin
                  foreach (pend[i]) expq.push_back(beat_t'{d: pend[i], l: (i == pend.size() - 1)});
                  nfr++;
                  pend.delete();
               end
               m_ovf = 1'b0;
            end else m_ovf = on;
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      commit = 1'b0;
      flush_n = 1'b1;
      if (rnd) axis.tready = 1'($urandom_range(0, 1));
   endtask
   task automatic put(input logic [63:0] d, input logic c);
      wr_en = 1'b1;
      wr_data = d;
      commit = c;
      tick();
   endtask
   task automatic drain();
      int k = 0;
      while (expq.size() > 0 && k < 500) begin
         tick();
         k++;
      end
      chk("drain", 64'(expq.size()), 64'(0));
      repeat (4) tick();
   endtask
   task automatic reset_dut();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask
   initial begin
      int lat;
      int len;
      logic fl;
      axis.tready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_empty", 64'(empty), 64'(1));
      chk("rst_full", 64'(full), 64'(0));
      chk("rst_drop", 64'(drop_cnt), 64'(0));
      chk("rst_tvalid", 64'(axis.tvalid), 64'(0));
      chk("rst_tlast", 64'(axis.tlast), 64'(0));
      chk("rst_tdata", axis.tdata, 64'(0));
      rst_n = 1'b1;
      tick();
      axis.tready = 1'b1;
      put(64'hA0, 1'b0);
      put(64'hA1, 1'b0);
      put(64'hA2, 1'b0);
      put(64'hA3, 1'b1);
      lat = 1;
      while (!axis.tvalid && lat < 10) begin
         tick();
         lat++;
      end
      chk("commit_latency", 64'(lat), 64'(2));
      drain();
      for (int i = 0; i < 3; i++) put(64'hB0 + 64'(i), 1'b0);
      flush_n = 1'b0;
      tick();
      chk("flush_empty", 64'(empty), 64'(1));
      repeat (4) tick();
      put(64'hC0, 1'b0);
      put(64'hC1, 1'b1);
      for (int i = 0; i < 3; i++) put(64'hD0 + 64'(i), 1'b0);
      flush_n = 1'b0;
      tick();
      put(64'hE0, 1'b1);
      drain();
      axis.tready = 1'b0;
      for (int i = 0; i < 20; i++) put(64'h100 + 64'(i), 1'(i == 19));
      repeat (3) tick();
      chk("ovf_drop", 64'(drop_cnt), 64'(1));
      chk("ovf_empty", 64'(empty), 64'(1));
      reset_dut();
      for (int i = 0; i < 9; i++) put(64'h200 + 64'(i), 1'b1);
      repeat (3) tick();
      chk("bq_drop", 64'(drop_cnt), 64'(1));
      axis.tready = 1'b1;
      drain();
      rnd = 1'b1;
      for (int f = 0; f < 30; f++) begin
         len = $urandom_range(1, 6);
         fl = $urandom_range(0, 5) == 0;
         for (int w = 0; w < len; w++) put({$urandom, $urandom}, 1'(w == len - 1 && !fl));
         if (fl) begin
            flush_n = 1'b0;
            tick();
         end
         if ($urandom_range(0, 7) == 0) begin
            commit = 1'b1;
            tick();
         end
         repeat ($urandom_range(0, 4)) tick();
      end
      drain();
      rnd = 1'b0;
      axis.tready = 1'b0;
      put(64'h301, 1'b0);
      put(64'h302, 1'b1);
      put(64'h303, 1'b0);
      reset_dut();
      chk("midrst_empty", 64'(empty), 64'(1));
      chk("midrst_tvalid", 64'(axis.tvalid), 64'(0));
      axis.tready = 1'b1;
      repeat (6) tick();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
